// File: rtl/fp_normalize_pack.sv
// ---------------------------------------------------------------------------
// fp_normalize_pack
//
// Back end of the FP adder datapath. Takes the raw unsigned mantissa sum,
// the common exponent from alignment and the result sign, normalizes the
// mantissa one shift per clock, and packs an IEEE-754 style result.
// Overflow forces infinity. Results too small to normalize are flushed to
// zero.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   in_valid     upstream sign/exponent/sum are valid
//   in_ready     block can accept a new operand (IDLE only)
//   sign_in      result sign
//   exponent_in  common exponent from alignment
//   sum_in       mantissa sum; [MANT_W+1] carry, [MANT_W] hidden-bit slot
//   out_valid    result and flags are valid (DONE state)
//   out_ready    downstream accepts the result
//   result       packed {sign, exponent, mantissa}
//   overflow     result forced to infinity
//   underflow    nonzero sum flushed to zero
//   zero         result is zero (zero sum or underflow)
//   shift_count  normalization steps taken for this result
// ---------------------------------------------------------------------------
module fp_normalize_pack #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      sign_in,
    input  logic [EXP_W-1:0]          exponent_in,
    input  logic [MANT_W+1:0]         sum_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     result,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      zero,
    output logic [4:0]                shift_count
);

    localparam logic [EXP_W-1:0] EXP_MAX      = '1;
    localparam logic [EXP_W-1:0] EXP_NEAR_MAX = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0] EXP_ONE      = EXP_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic                    sign_q, sign_next;
    logic [EXP_W-1:0]        exp_q, exp_next;
    logic [MANT_W+1:0]       mant_q, mant_next;
    logic [EXP_W+MANT_W:0]   result_next;
    logic                    overflow_next, underflow_next, zero_next;
    logic [4:0]              shift_count_next;

    logic [EXP_W+MANT_W:0]   inf_word;
    logic [EXP_W+MANT_W:0]   zero_word;

    assign inf_word  = {sign_q, EXP_MAX, {MANT_W{1'b0}}};
    assign zero_word = {sign_q, {(EXP_W+MANT_W){1'b0}}};

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        sign_next        = sign_q;
        exp_next         = exp_q;
        mant_next        = mant_q;
        result_next      = result;
        overflow_next    = overflow;
        underflow_next   = underflow;
        zero_next        = zero;
        shift_count_next = shift_count;
        in_ready         = 1'b0;
        out_valid        = 1'b0;

        case (state)
            IDLE: begin
                // Held low while reset is asserted even though state is IDLE.
                in_ready = ~reset;
                if (in_valid) begin
                    sign_next        = sign_in;
                    exp_next         = exponent_in;
                    mant_next        = sum_in;
                    result_next      = '0;
                    overflow_next    = 1'b0;
                    underflow_next   = 1'b0;
                    zero_next        = 1'b0;
                    shift_count_next = '0;
                    state_next       = NORM;
                end
            end

            NORM: begin
                if (exp_q == EXP_MAX) begin
                    result_next   = inf_word;
                    overflow_next = 1'b1;
                    state_next    = DONE;
                end else if (mant_q == '0) begin
                    result_next = zero_word;
                    zero_next   = 1'b1;
                    state_next  = DONE;
                end else if (mant_q[MANT_W+1]) begin
                    // Carry out: a right shift would push the exponent to
                    // EXP_MAX, which is infinity.
                    if (exp_q == EXP_NEAR_MAX) begin
                        result_next   = inf_word;
                        overflow_next = 1'b1;
                        state_next    = DONE;
                    end else begin
                        mant_next        = mant_q >> 1;
                        exp_next         = exp_q + EXP_ONE;
                        shift_count_next = shift_count + 5'd1;
                    end
                end else if (mant_q[MANT_W]) begin
                    result_next = {sign_q, exp_q, mant_q[MANT_W-1:0]};
                    state_next  = DONE;
                end else if (exp_q <= EXP_ONE) begin
                    // No denormals: anything that cannot normalize flushes.
                    result_next    = zero_word;
                    underflow_next = 1'b1;
                    zero_next      = 1'b1;
                    state_next     = DONE;
                end else begin
                    mant_next        = mant_q << 1;
                    exp_next         = exp_q - EXP_ONE;
                    shift_count_next = shift_count + 5'd1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values computed above from the same pre-edge state.
    // NOTE: the working registers are reset too, so an aborted operation
    // leaves nothing behind on result or the flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            zero        <= 1'b0;
            shift_count <= '0;
        end else begin
            state       <= state_next;
            sign_q      <= sign_next;
            exp_q       <= exp_next;
            mant_q      <= mant_next;
            result      <= result_next;
            overflow    <= overflow_next;
            underflow   <= underflow_next;
            zero        <= zero_next;
            shift_count <= shift_count_next;
        end
    end

endmodule

// File: doc/fp_normalize_pack.md
Name: fp_normalize_pack

Overview:
- Back end of the FP adder datapath, the counterpart to mask/alignment. Alignment unpacks operands and produces a common exponent. This block takes the raw mantissa sum, the common exponent and the result sign, and produces a packed IEEE-754 single.
- Normalization is iterative: one shift per clock, under a valid/ready handshake on both sides.
- Also flags overflow, underflow and zero results.

Parameters:
- MANT_W, 23, stored mantissa width (hidden bit excluded); the sum input is MANT_W+2 bits wide.
- EXP_W, 8, exponent width; EXP_MAX = 2**EXP_W-1 encodes infinity.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; all state cleared immediately.
- in_valid  input  1  upstream sum/exponent/sign are valid.
- in_ready  output  1  block can accept a new operand.
- sign_in  input  1  result sign.
- exponent_in  input  EXP_W  common exponent from alignment.
- sum_in  input  MANT_W+2  unsigned mantissa sum; bit 24 is carry, bit 23 is hidden-bit position.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- result  output  1+EXP_W+MANT_W  packed {sign, exponent, mantissa}.
- overflow  output  1  result forced to infinity.
- underflow  output  1  nonzero sum flushed to zero.
- zero  output  1  result is zero (zero sum or underflow).
- shift_count  output  5  number of normalization steps taken for this result.

Behaviour:
- Reset: already decided — one clock, reset asynchronous and active-high.
  - While reset is high: state=IDLE; result=0, out_valid=0, overflow=0, underflow=0, zero=0, shift_count=0, in_ready=0.
  - After release: in_ready=1.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready at a clock edge, capture sign, exponent and sum; clear shift_count; go to NORM.
  - NORM: in_ready=0. Exactly one of the following happens per edge, checked in priority order:
    - (a) captured exp==EXP_MAX: result=infinity, overflow=1, go to DONE.
    - (b) mant==0: result={sign,0}, zero=1, go to DONE.
    - (c) mant[24]=1: if exp==EXP_MAX-1, result=infinity, overflow=1. Otherwise mant>>=1 (LSB truncated, no rounding), exp+=1, shift_count+=1, stay in NORM.
    - (d) mant[24:23]==2'b01: result={sign,exp,mant[22:0]}, go to DONE.
    - (e) mant[23]=0 with exp<=1: result={sign,0}, underflow=1, zero=1, go to DONE.
    - (f) otherwise: mant<<=1, exp-=1, shift_count+=1, stay in NORM.
  - DONE: out_valid=1. result and all flags held stable while out_ready=0. On out_ready, go to IDLE and drop out_valid on that edge.
- Throughput and latency:
  - No accept in the same cycle as the DONE handshake; throughput is one result per S+3 cycles minimum.
  - Latency from the accept edge to out_valid high = S+1 edges, where S = shift_count.
  - At most 1 right shift or 23 left shifts, so S<=23.
- Infinity encoding = {sign, EXP_MAX, 0}.
- Flags and shift_count are cleared on each new accept.
- Denormal outputs are not produced; flush-to-zero only.
- Reset mid-NORM or mid-DONE aborts the operation with no partial output; the block is back in IDLE after release.

Test Plan:
- sum_in=25'h0800000, exp=127, sign=0:
  - out_valid 1 edge after accept; result=32'h3F800000, shift_count=0, all flags 0.
- sum_in=25'h1800000, exp=127:
  - result=32'h40400000, shift_count=1, out_valid 2 edges after accept.
- sum_in=25'h0000001, exp=127:
  - result=32'h34000000, shift_count=23, out_valid 24 edges after accept.
  - Hold out_ready=0 for 5 cycles: result stays stable and in_ready stays 0.
- sum_in=0, sign=1:
  - result=32'h80000000, zero=1.
- sum_in=25'h1000000, exp=254:
  - result=32'h7F800000, overflow=1.
- sum_in=25'h0000100, exp=3:
  - underflow=1, zero=1, result=32'h00000000.
- Reset mid-operation: start sum_in=25'h0000001, assert reset after 5 cycles:
  - out_valid=0 immediately; in_ready=1 one cycle after release.
  - Next accepted operand produces a correct result.
